dcls_lockstep_cmp: RTL
======================

# dcls_lockstep_cmp

Parametrised lockstep front/back end for the dual-core lockstep (DCLS) pair. It delays an arbitrary-width input bundle and the reset to the shadow core by DELAY cycles. It delays the main core's output bundle by the same amount and compares it against the shadow core's outputs. Mismatches are reported as a per-cycle pulse, a sticky error, a saturating count and a first-error syndrome. It sits between the SoC-facing ports and the main/shadow core pair.

## Interface
- DELAY, 2, lockstep skew in cycles; legal range 1..16
- IN_W, 204, width of packed input bundle fed to the shadow core
- OUT_W, 128, width of packed output bundle compared
- CMP_MASK, all ones (OUT_W bits), per-bit compare enable; 0 excludes the bit
- CNT_W, 8, width of mismatch counter
- clk_i  in  1  clock; one clock; all state on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- in_data_i  in  IN_W  input bundle as presented to the main core
- in_data_o  out  IN_W  in_data_i delayed DELAY cycles, to the shadow core
- shadow_rst_o  out  1  reset to the shadow core, delayed DELAY cycles
- main_out_i  in  OUT_W  main core output bundle
- shadow_out_i  in  OUT_W  shadow core output bundle
- cmp_en_i  in  1  compare enable (software/debug gate)
- err_clr_i  in  1  clears err_o, err_cnt_o, err_syndrome_o
- armed_o  out  1  comparison pipeline is filled and valid
- mismatch_o  out  1  one-cycle pulse per detected mismatch
- err_o  out  1  sticky error
- err_cnt_o  out  CNT_W  saturating mismatch count
- err_syndrome_o  out  OUT_W  masked XOR of the first mismatch since the last clear

## Operation
- Input pipe: DELAY-stage shift register. Reset value 0. Shifts every cycle and has no enable.
- Reset pipe: DELAY-stage shift register, reset to all 1s, shifting in 0. shadow_rst_o = last stage.
  - shadow_rst_o is high during rst_i and for DELAY cycles after rst_i deasserts.
- Main output pipe: DELAY-stage shift register of main_out_i, reset to 0. It carries a parallel valid bit, reset to 0, which shifts in 1 every cycle.
- armed_o = valid bit of the last stage. It goes high exactly DELAY cycles after rst_i deasserts.
- Compare stage: diff = (main_pipe_last ^ shadow_out_i) & CMP_MASK. A hit is raised when armed_o & cmp_en_i & (diff != 0).
- Hit result, registered:
  - mismatch_o = 1 for one cycle.
  - err_o set.
  - err_cnt_o increments, saturating at 2^CNT_W-1.
  - err_syndrome_o loads diff only if err_o was 0, so it holds the first error.
- err_clr_i and a hit in the same cycle: the clear is applied first, then the hit. Result: err_o=1, err_cnt_o=1, err_syndrome_o = new diff.
- err_clr_i alone: err_o=0, err_cnt_o=0, err_syndrome_o=0 next cycle. mismatch_o is unaffected.
- cmp_en_i low: pipes keep shifting; no hits; the error state holds.
- Asserting rst_i mid-operation immediately (asynchronously) forces:
  - all pipe stages and valid bits to reset values;
  - shadow_rst_o=1, armed_o=0;
  - mismatch_o=0, err_o=0, err_cnt_o=0, err_syndrome_o=0.

## Timing
- in_data_o at cycle t+DELAY equals in_data_i at cycle t.
- main_out_i sampled at cycle t is compared with shadow_out_i at cycle t+DELAY. On a mismatch, mismatch_o/err_o are high at cycle t+DELAY+1.
- Total detection latency is DELAY+1 cycles from the main-core output.
- Reset values of all outputs:
  - in_data_o=0, shadow_rst_o=1, armed_o=0;
  - mismatch_o=0, err_o=0, err_cnt_o=0, err_syndrome_o=0.
- After rst_i falls at edge r:
  - shadow_rst_o falls and armed_o rises at edge r+DELAY.
  - The first possible mismatch_o is at r+DELAY+1.
- Every output is a register output; no combinational path from inputs to outputs.

## Structure
- Shared header dcls_defs.vh holds:
  - default DELAY;
  - a DCLS_MAX_DELAY=16 constant, with an elaboration check on DELAY;
  - bundle widths IN_W/OUT_W and the bit-field offsets used to pack/unpack the core ports.
- One sub-module, dcls_shift_reg (params WIDTH, DEPTH, RST_VAL), with async active-high reset. It is instantiated for the input pipe, the main-output pipe and the combined reset/valid pipe.
- Compare, counter and syndrome logic are in the top level.

## Test plan
- Reset release, DELAY=2 -> shadow_rst_o falls and armed_o rises exactly 2 edges after rst_i falls. in_data_i=0xA5 at t gives in_data_o=0xA5 at t+2.
- Identical traffic, main_out_i(t)=shadow_out_i(t+2)=random for 1000 cycles -> mismatch_o never asserts; err_cnt_o=0.
- Single injected flip: bit 5 of shadow_out_i inverted in one cycle -> one mismatch_o pulse; err_o=1; err_cnt_o=1; err_syndrome_o=0x20.
  - A second flip of bit 9 then gives err_cnt_o=2 with the syndrome still 0x20.
- Saturation with CNT_W=2: 5 consecutive mismatches -> err_cnt_o sticks at 3.
  - err_clr_i in the same cycle as a hit -> err_cnt_o=1, syndrome = new diff.
- Masking and gating:
  - CMP_MASK bit 0 = 0 with a bit-0 flip -> no mismatch.
  - cmp_en_i=0 with a full-word flip -> no mismatch, err state held.
- Mid-run reset asserted asynchronously between edges -> all outputs reach reset values before the next edge. Re-arming follows the reset-release timing.

Source files
------------

// File: rtl/dcls_lockstep_cmp_pkg.sv
// Shared constants for the DCLS lockstep comparator: default skew, bundle widths and
// the bit-field layout of the packed core-port bundles.
package dcls_lockstep_cmp_pkg;

   localparam int unsigned DCLS_MAX_DELAY     = 16;
   localparam int unsigned DCLS_DEFAULT_DELAY = 2;
   localparam int unsigned DCLS_IN_W          = 204;
   localparam int unsigned DCLS_OUT_W         = 128;

   // Input bundle: instr | rdata | irq | ctrl, LSB first.
   localparam int unsigned DCLS_IN_INSTR_OFF  = 0;
   localparam int unsigned DCLS_IN_INSTR_W    = 32;
   localparam int unsigned DCLS_IN_RDATA_OFF  = 32;
   localparam int unsigned DCLS_IN_RDATA_W    = 64;
   localparam int unsigned DCLS_IN_IRQ_OFF    = 96;
   localparam int unsigned DCLS_IN_IRQ_W      = 32;
   localparam int unsigned DCLS_IN_CTRL_OFF   = 128;
   localparam int unsigned DCLS_IN_CTRL_W     = 76;

   // Output bundle: addr | wdata | ctrl, LSB first.
   localparam int unsigned DCLS_OUT_ADDR_OFF  = 0;
   localparam int unsigned DCLS_OUT_ADDR_W    = 32;
   localparam int unsigned DCLS_OUT_WDATA_OFF = 32;
   localparam int unsigned DCLS_OUT_WDATA_W   = 64;
   localparam int unsigned DCLS_OUT_CTRL_OFF  = 96;
   localparam int unsigned DCLS_OUT_CTRL_W    = 32;

   // True when the field map tiles both bundles exactly with no gaps or overlap.
   function automatic bit dcls_layout_ok();
      return (DCLS_IN_INSTR_OFF == 0)
          && (DCLS_IN_RDATA_OFF == DCLS_IN_INSTR_OFF + DCLS_IN_INSTR_W)
          && (DCLS_IN_IRQ_OFF   == DCLS_IN_RDATA_OFF + DCLS_IN_RDATA_W)
          && (DCLS_IN_CTRL_OFF  == DCLS_IN_IRQ_OFF + DCLS_IN_IRQ_W)
          && (DCLS_IN_W         == DCLS_IN_CTRL_OFF + DCLS_IN_CTRL_W)
          && (DCLS_OUT_ADDR_OFF == 0)
          && (DCLS_OUT_WDATA_OFF == DCLS_OUT_ADDR_OFF + DCLS_OUT_ADDR_W)
          && (DCLS_OUT_CTRL_OFF  == DCLS_OUT_WDATA_OFF + DCLS_OUT_WDATA_W)
          && (DCLS_OUT_W         == DCLS_OUT_CTRL_OFF + DCLS_OUT_CTRL_W);
   endfunction

endpackage

// File: rtl/dcls_shift_reg.sv
// Fixed-depth shift register with asynchronous active-high reset to RST_VAL.
module dcls_shift_reg #(
   parameter int unsigned      WIDTH   = 1,
   parameter int unsigned      DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            stage_q[i] <= RST_VAL;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < int'(DEPTH); i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dcls_lockstep_cmp.sv
// Lockstep front/back end: skews inputs and reset to the shadow core and compares the
// delayed main-core outputs against the shadow outputs with sticky error reporting.
module dcls_lockstep_cmp
   import dcls_lockstep_cmp_pkg::*;
#(
   parameter int unsigned      DELAY    = DCLS_DEFAULT_DELAY,
   parameter int unsigned      IN_W     = DCLS_IN_W,
   parameter int unsigned      OUT_W    = DCLS_OUT_W,
   parameter logic [OUT_W-1:0] CMP_MASK = '1,
   parameter int unsigned      CNT_W    = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [IN_W-1:0]  in_data_i,
   output logic [IN_W-1:0]  in_data_o,
   output logic             shadow_rst_o,
   input  logic [OUT_W-1:0] main_out_i,
   input  logic [OUT_W-1:0] shadow_out_i,
   input  logic             cmp_en_i,
   input  logic             err_clr_i,
   output logic             armed_o,
   output logic             mismatch_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [OUT_W-1:0] err_syndrome_o
);

   if (DELAY < 1 || DELAY > DCLS_MAX_DELAY) begin : g_bad_delay
      $error("dcls_lockstep_cmp: DELAY must be in 1..%0d", DCLS_MAX_DELAY);
   end

   if (!dcls_layout_ok()) begin : g_bad_layout
      $error("dcls_lockstep_cmp: bundle field map does not tile the bundle widths");
   end

   logic [OUT_W-1:0] main_last;
   logic [1:0]       ctl_last;

   dcls_shift_reg #(
      .WIDTH   (IN_W),
      .DEPTH   (DELAY),
      .RST_VAL ('0)
   ) u_in_pipe (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (in_data_i),
      .q_o   (in_data_o)
   );

   dcls_shift_reg #(
      .WIDTH   (OUT_W),
      .DEPTH   (DELAY),
      .RST_VAL ('0)
   ) u_main_pipe (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (main_out_i),
      .q_o   (main_last)
   );

   // Bit 1 is the shadow reset (flushes to 0), bit 0 the compare-valid flag (fills with 1).
   dcls_shift_reg #(
      .WIDTH   (2),
      .DEPTH   (DELAY),
      .RST_VAL (2'b10)
   ) u_ctl_pipe (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (2'b01),
      .q_o   (ctl_last)
   );

   assign shadow_rst_o = ctl_last[1];
   assign armed_o      = ctl_last[0];

   logic [OUT_W-1:0] diff;
   logic             hit;

   assign diff = (main_last ^ shadow_out_i) & CMP_MASK;
   assign hit  = armed_o & cmp_en_i & (|diff);

   logic             mismatch_q;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] syn_q, syn_d;

   // A clear takes effect before a same-cycle hit, so the hit becomes the new first error.
   always_comb begin
      err_d = err_q;
      cnt_d = cnt_q;
      syn_d = syn_q;
      if (err_clr_i) begin
         err_d = 1'b0;
         cnt_d = '0;
         syn_d = '0;
      end
      if (hit) begin
         if (!err_d) begin
            syn_d = diff;
         end
         err_d = 1'b1;
         if (cnt_d != '1) begin
            cnt_d = cnt_d + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mismatch_q <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         syn_q      <= '0;
      end else begin
         mismatch_q <= hit;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         syn_q      <= syn_d;
      end
   end

   assign mismatch_o     = mismatch_q;
   assign err_o          = err_q;
   assign err_cnt_o      = cnt_q;
   assign err_syndrome_o = syn_q;

endmodule
